// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with division fast paths, pipeline flush and a tagged result.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
        neg_x = en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
        neg_2x = en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]        state_r;
    logic [2:0]        op_r;
    logic [TAG_W-1:0]  tag_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [CW-1:0]     count_r;
    logic [XLEN-1:0]   opa_r;
    logic [XLEN-1:0]   opb_r;
    logic [2*XLEN-1:0] work_r;
    logic [XLEN-1:0]   result_r;
    logic [TAG_W-1:0]  tag_out_r;
    logic              busy_r;
    logic              done_r;

    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_val_s;

    logic [2*XLEN-1:0] mul_add_s;
    logic [XLEN:0]     div_top_s;
    logic [XLEN:0]     div_diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   final_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign tag_out = tag_out_r;

    // Request decode: operand signedness, magnitudes and division special cases.
    always_comb begin
        a_neg_s    = 1'b0;
        b_neg_s    = 1'b0;
        fast_s     = 1'b0;
        fast_val_s = {XLEN{1'b0}};
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_neg_s = a[XLEN-1];
                b_neg_s = b[XLEN-1];
            end
            3'b010: begin
                a_neg_s = a[XLEN-1];
            end
            default: begin
                a_neg_s = 1'b0;
                b_neg_s = 1'b0;
            end
        endcase
        a_mag_s = neg_x(a, a_neg_s);
        b_mag_s = neg_x(b, b_neg_s);
        if (funct3[2] && (b == {XLEN{1'b0}})) begin
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? a : {XLEN{1'b1}};
        end else if (funct3[2] && !funct3[0] && (a == MOST_NEG) && (b == {XLEN{1'b1}})) begin
            fast_s     = 1'b1;
            fast_val_s = funct3[1] ? {XLEN{1'b0}} : a;
        end else begin
            fast_s     = 1'b0;
            fast_val_s = {XLEN{1'b0}};
        end
    end

    // One iteration: MSB-first shift-add, or a restoring step on {rem, quo}.
    always_comb begin
        mul_add_s  = {(2*XLEN){1'b0}};
        div_top_s  = work_r[2*XLEN-1:XLEN-1];
        div_diff_s = div_top_s - {1'b0, opb_r};
        if (opa_r[XLEN-1]) begin
            mul_add_s = {{XLEN{1'b0}}, opb_r};
        end else begin
            mul_add_s = {(2*XLEN){1'b0}};
        end
        if (!op_r[2]) begin
            step_s = {work_r[2*XLEN-2:0], 1'b0} + mul_add_s;
        end else if (!div_diff_s[XLEN]) begin
            step_s = {div_diff_s[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
        end else begin
            step_s = {div_top_s[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
        end
    end

    // Result selection with sign correction, taken from the final iteration value.
    always_comb begin
        prod_s = neg_2x(step_s, neg_q_r);
        case (op_r)
            3'b000:                 final_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_s = neg_x(step_s[XLEN-1:0], neg_q_r);
            3'b110, 3'b111:         final_s = neg_x(step_s[2*XLEN-1:XLEN], neg_r_r);
            default:                final_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM, operand latches, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 3'b000;
            tag_r     <= {TAG_W{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            count_r   <= {CW{1'b0}};
            opa_r     <= {XLEN{1'b0}};
            opb_r     <= {XLEN{1'b0}};
            work_r    <= {(2*XLEN){1'b0}};
            result_r  <= {XLEN{1'b0}};
            tag_out_r <= {TAG_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_r    <= funct3;
                        tag_r   <= tag_in;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        count_r <= {CW{1'b0}};
                        opa_r   <= a_mag_s;
                        opb_r   <= b_mag_s;
                        work_r  <= funct3[2] ? {{XLEN{1'b0}}, a_mag_s} : {(2*XLEN){1'b0}};
                        busy_r  <= 1'b1;
                        if (fast_s) begin
                            state_r   <= ST_DONE;
                            result_r  <= fast_val_s;
                            tag_out_r <= tag_in;
                            done_r    <= 1'b1;
                        end else begin
                            state_r <= ST_CALC;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                        work_r  <= step_s;
                        opa_r   <= {opa_r[XLEN-2:0], 1'b0};
                        if (count_r == CW'(XLEN - 1)) begin
                            state_r   <= ST_DONE;
                            result_r  <= final_s;
                            tag_out_r <= tag_r;
                            done_r    <= 1'b1;
                        end else begin
                            done_r <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    // Leaves DONE regardless of flush; the visible pulse stands.
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, flush/reset scenarios
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [4:0]  tag_in = 5'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .tag_in(tag_in), .busy(busy), .done(done),
        .result(result), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    bit          prev_done = 1'b0;
    logic [31:0] last_res = 32'h0;
    logic [4:0]  last_tag = 5'h0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit / 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        ix = $signed(x);
        iy = $signed(y);
        p  = 64'h0;
        r  = 32'h0;
        case (f)
            3'd0: begin p = 64'(ux * uy); r = p[31:0];  end
            3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
            3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
            3'd3: begin p = 64'(ux * uy); r = p[63:32]; end
            3'd4: r = (y == 32'h0) ? 32'hFFFFFFFF :
                      ((x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : 32'(ix / iy));
            3'd5: r = (y == 32'h0) ? 32'hFFFFFFFF : x / y;
            3'd6: r = (y == 32'h0) ? x :
                      ((x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h0 : 32'(ix % iy));
            default: r = (y == 32'h0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Cycles from the accepting edge until done is visible.
    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 32'h0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
            return 0;
        return 32;
    endfunction

    // Monitor: every done pulse pops one expectation and checks value, tag and timing.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done++;
            if (prev_done) check("done_single_cycle", 64'd1, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {59'h0, tag_out}, 64'hFFFF);
            end else begin
                e = sb.pop_front();
                check("result", {32'h0, result}, {32'h0, e.res});
                check("tag_out", {59'h0, tag_out}, {59'h0, e.tag});
                check("done_cycle", 64'(cyc), 64'(e.due));
                last_res = e.res;
                last_tag = e.tag;
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] tg, input logic [31:0] exp_res, input bit track);
        exp_t e;
        wait_idle();
        start = 1'b1; funct3 = f; a = x; b = y; tag_in = tg;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; funct3 = 3'($urandom); tag_in = 5'($urandom);
        check("busy_after_accept", {63'h0, busy}, 64'd1);
        if (track) begin
            e.res = exp_res;
            e.tag = tg;
            e.due = cyc + latency(f, x, y);
            sb.push_back(e);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_f[13]   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a[13]   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h80000000, 32'h80000000};
    logic [31:0] d_b[13]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'h0, 32'h0,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp[13] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                               32'h80000000, 32'h0};

    initial begin
        int nd;
        int k;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        #12;
        check("reset_busy", {63'h0, busy}, 64'd0);
        check("reset_done", {63'h0, done}, 64'd0);
        check("reset_result", {32'h0, result}, 64'd0);
        check("reset_tag", {59'h0, tag_out}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(d_f[i], d_a[i], d_b[i], 5'(i + 5), d_exp[i], 1'b1);
        end

        // Flush ten cycles into a DIVU: no done, outputs hold the previous result.
        wait_idle();
        issue(3'd5, 32'd1000, 32'd7, 5'd20, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("busy_after_flush", {63'h0, busy}, 64'd0);
        nd = n_done;
        repeat (40) @(negedge clk);
        check("no_done_after_flush", 64'(n_done), 64'(nd));
        check("result_held", {32'h0, result}, {32'h0, last_res});
        check("tag_held", {59'h0, tag_out}, {59'h0, last_tag});

        // start together with flush in IDLE is dropped.
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("start_with_flush_dropped", {63'h0, busy}, 64'd1 - 64'd1);

        // start pulsed mid-CALC and in the done cycle is ignored.
        issue(3'd5, 32'd1000, 32'd7, 5'd21, 32'd142, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd9; tag_in = 5'd30;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", {63'h0, done}, 64'd1);
        start = 1'b1; funct3 = 3'd4; a = 32'd5; b = 32'h0; tag_in = 5'd31;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_ignored", {63'h0, busy}, 64'd0);
        nd = n_done;
        repeat (3) @(negedge clk);
        check("no_done_from_ignored", 64'(n_done), 64'(nd));
        issue(3'd7, 32'd100, 32'd9, 5'd22, 32'd1, 1'b1);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        issue(3'd0, 32'd77, 32'd5, 5'd23, 32'd385, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", {63'h0, busy}, 64'd0);
        check("async_rst_done", {63'h0, done}, 64'd0);
        check("async_rst_result", {32'h0, result}, 64'd0);
        check("async_rst_tag", {59'h0, tag_out}, 64'd0);
        sb.delete();
        last_res = 32'h0;
        last_tag = 5'h0;
        @(negedge clk);
        rst = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 5'd24, 32'd12, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            issue(rf, ra, rb, 5'($urandom), model(rf, ra, rb), 1'b1);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
